// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC multiplexed-bus controller.
// State encoding, counter type and RTC register map.
package rtc_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_A_SU  = 4'd1,
    S_A_STB = 4'd2,
    S_A_HLD = 4'd3,
    S_GAP   = 4'd4,
    S_D_SU  = 4'd5,
    S_D_STB = 4'd6,
    S_D_HLD = 4'd7,
    S_FIN   = 4'd8
  } state_t;

  typedef logic [7:0] cnt_t;

  localparam logic [7:0] REG_SEC  = 8'h21;
  localparam logic [7:0] REG_MIN  = 8'h22;
  localparam logic [7:0] REG_HOUR = 8'h23;
  localparam logic [7:0] REG_DAY  = 8'h24;
  localparam logic [7:0] REG_MON  = 8'h25;
  localparam logic [7:0] REG_YEAR = 8'h26;
  localparam logic [7:0] REG_TMR0 = 8'h41;
  localparam logic [7:0] REG_TMR1 = 8'h42;
  localparam logic [7:0] REG_TMR2 = 8'h43;
  localparam logic [7:0] REG_XFER = 8'hF0;

  // A zero duration still occupies one cycle.
  function automatic cnt_t ld(int unsigned n);
    return (n == 0) ? '0 : cnt_t'(n - 1);
  endfunction

  function automatic state_t nxt(state_t s);
    case (s)
      S_A_SU:  return S_A_STB;
      S_A_STB: return S_A_HLD;
      S_A_HLD: return S_GAP;
      S_GAP:   return S_D_SU;
      S_D_SU:  return S_D_STB;
      S_D_STB: return S_D_HLD;
      S_D_HLD: return S_FIN;
      default: return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/rtc_bus_ctrl_if.sv
// Host-side request/response and RTC pin bundle.
// slave = controller view, master = host/pin-model view.
interface rtc_bus_ctrl_if;
  logic       act_rtc;
  logic       wr_en;
  logic [7:0] dir;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       rtc_cs_n;
  logic       rtc_ad;
  logic       rtc_wr_n;
  logic       rtc_rd_n;
  logic [7:0] rtc_dq_o;
  logic       rtc_dq_oe;
  logic [7:0] rtc_dq_i;

  modport slave (
    input  act_rtc, wr_en, dir, wdata, rtc_dq_i,
    output rdata, busy, done,
    output rtc_cs_n, rtc_ad, rtc_wr_n, rtc_rd_n,
    output rtc_dq_o, rtc_dq_oe
  );

  modport master (
    output act_rtc, wr_en, dir, wdata, rtc_dq_i,
    input  rdata, busy, done,
    input  rtc_cs_n, rtc_ad, rtc_wr_n, rtc_rd_n,
    input  rtc_dq_o, rtc_dq_oe
  );
endinterface

// File: rtl/rtc_bus_ctrl.sv
// Sequences one address phase plus one data phase on the RTC
// multiplexed bus; all pin outputs are registered.
module rtc_bus_ctrl
  import rtc_pkg::*;
#(
  parameter int unsigned T_SETUP  = 2,
  parameter int unsigned T_STROBE = 6,
  parameter int unsigned T_HOLD   = 2,
  parameter int unsigned T_GAP    = 4
) (
  input logic           clk,
  input logic           rst_n,
  rtc_bus_ctrl_if.slave bus
);

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic       wr_q, wr_d;
  logic [7:0] dir_q, dir_d;
  logic [7:0] wdat_q, wdat_d;
  logic [7:0] rdata_q, rdata_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       cs_n_q, cs_n_d;
  logic       ad_q, ad_d;
  logic       wr_n_q, wr_n_d;
  logic       rd_n_q, rd_n_d;
  logic [7:0] dq_o_q, dq_o_d;
  logic       oe_q, oe_d;

  function automatic cnt_t reload(state_t s);
    case (s)
      S_A_SU, S_D_SU:   return ld(T_SETUP);
      S_A_STB, S_D_STB: return ld(T_STROBE);
      S_A_HLD, S_D_HLD: return ld(T_HOLD);
      S_GAP:            return ld(T_GAP);
      default:          return '0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    dir_d   = dir_q;
    wdat_d  = wdat_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (bus.act_rtc) begin
          state_d = S_A_SU;
          wr_d    = bus.wr_en;
          dir_d   = bus.dir;
          wdat_d  = bus.wdata;
          busy_d  = 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        if (cnt_q == '0) state_d = nxt(state_q);
      end
    endcase

    if (state_d != state_q) cnt_d = reload(state_d);
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;

    // Capture on the final strobe-low cycle, just before rd_n rises.
    if (state_q == S_D_STB && cnt_q == '0 && !wr_q)
      rdata_d = bus.rtc_dq_i;

    // Pin values are derived from the state being entered.
    cs_n_d = 1'b1;
    ad_d   = 1'b1;
    wr_n_d = 1'b1;
    rd_n_d = 1'b1;
    oe_d   = 1'b0;
    dq_o_d = '0;
    case (state_d)
      S_A_SU, S_A_STB, S_A_HLD: begin
        cs_n_d = 1'b0;
        ad_d   = 1'b0;
        oe_d   = 1'b1;
        dq_o_d = dir_d;
        wr_n_d = (state_d != S_A_STB);
      end
      S_D_SU, S_D_STB, S_D_HLD: begin
        cs_n_d = 1'b0;
        if (wr_d) begin
          oe_d   = 1'b1;
          dq_o_d = wdat_d;
          wr_n_d = (state_d != S_D_STB);
        end else begin
          rd_n_d = (state_d != S_D_STB);
        end
      end
      default: ;
    endcase
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      dir_q   <= '0;
      wdat_q  <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      ad_q    <= 1'b1;
      wr_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      dq_o_q  <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      dir_q   <= dir_d;
      wdat_q  <= wdat_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_n_q  <= cs_n_d;
      ad_q    <= ad_d;
      wr_n_q  <= wr_n_d;
      rd_n_q  <= rd_n_d;
      dq_o_q  <= dq_o_d;
      oe_q    <= oe_d;
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rtc_cs_n  = cs_n_q;
  assign bus.rtc_ad    = ad_q;
  assign bus.rtc_wr_n  = wr_n_q;
  assign bus.rtc_rd_n  = rd_n_q;
  assign bus.rtc_dq_o  = dq_o_q;
  assign bus.rtc_dq_oe = oe_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Directed bench for rtc_bus_ctrl: vector table of single
// transactions plus sequences for overlap, reset and back-to-back.
module tb_rtc_bus_ctrl;
  import rtc_pkg::*;

  logic clk;
  logic rst_n;
  rtc_bus_ctrl_if bus ();

  rtc_bus_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("strobe_excl", int'(!bus.rtc_wr_n && !bus.rtc_rd_n), 0);
      chk("strobe_no_cs",
          int'(bus.rtc_cs_n && (!bus.rtc_wr_n || !bus.rtc_rd_n)), 0);
      chk("oe_on_read", int'(!bus.rtc_rd_n && bus.rtc_dq_oe), 0);
    end
  end

  typedef struct {
    logic       w;
    logic [7:0] dir;
    logic [7:0] wdata;
    logic [7:0] dqi;
    logic [7:0] exp_rdata;
    int         exp_wrl;
    int         exp_rdl;
    int         exp_doe;
    logic [7:0] exp_data;
  } vec_t;

  int         o_lat, o_busy, o_wrl, o_rdl, o_doe, o_done, o_after;
  logic [7:0] o_addr, o_data, o_rd;

  task automatic run_txn(input logic w, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] q);
    o_lat = 0; o_busy = 0; o_wrl = 0; o_rdl = 0;
    o_doe = 0; o_done = 0; o_addr = '0; o_data = '0; o_rd = '0;
    @(negedge clk);
    bus.wr_en = w; bus.dir = a; bus.wdata = d;
    bus.rtc_dq_i = q; bus.act_rtc = 1'b1;
    @(posedge clk);
    #1 bus.act_rtc = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.busy) o_busy++;
      if (!bus.rtc_wr_n) o_wrl++;
      if (!bus.rtc_rd_n) o_rdl++;
      if (!bus.rtc_ad && !bus.rtc_wr_n) o_addr = bus.rtc_dq_o;
      if (bus.rtc_ad && !bus.rtc_cs_n && bus.rtc_dq_oe) begin
        o_data = bus.rtc_dq_o;
        o_doe++;
      end
      if (bus.done) begin
        o_done++;
        o_lat = c;
        o_rd = bus.rdata;
        break;
      end
    end
    @(negedge clk);
    o_after = int'(bus.busy);
  endtask

  vec_t vt[5];
  int   cnt;
  int   dn;

  initial begin
    vt[0] = '{1'b1, REG_SEC,  8'h59, 8'hEE, 8'h00, 12, 0, 10, 8'h59};
    vt[1] = '{1'b0, REG_HOUR, 8'h00, 8'h12, 8'h12,  6, 6,  0, 8'h00};
    vt[2] = '{1'b1, REG_TMR0, 8'hAA, 8'hEE, 8'h12, 12, 0, 10, 8'hAA};
    vt[3] = '{1'b0, REG_XFER, 8'h00, 8'h5A, 8'h5A,  6, 6,  0, 8'h00};
    vt[4] = '{1'b0, REG_YEAR, 8'hFF, 8'h00, 8'h00,  6, 6,  0, 8'h00};

    rst_n = 1'b0;
    bus.act_rtc = 1'b0; bus.wr_en = 1'b0;
    bus.dir = '0; bus.wdata = '0; bus.rtc_dq_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_pins", int'({bus.rtc_cs_n, bus.rtc_ad, bus.rtc_wr_n,
        bus.rtc_rd_n, bus.rtc_dq_oe, bus.busy, bus.done}), 'h78);
    chk("rst_dq_o", int'(bus.rtc_dq_o), 0);
    chk("rst_rdata", int'(bus.rdata), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_txn(vt[i].w, vt[i].dir, vt[i].wdata, vt[i].dqi);
      chk($sformatf("v%0d_lat", i), o_lat, 25);
      chk($sformatf("v%0d_busy", i), o_busy, 25);
      chk($sformatf("v%0d_done", i), o_done, 1);
      chk($sformatf("v%0d_after", i), o_after, 0);
      chk($sformatf("v%0d_wrl", i), o_wrl, vt[i].exp_wrl);
      chk($sformatf("v%0d_rdl", i), o_rdl, vt[i].exp_rdl);
      chk($sformatf("v%0d_addr", i), int'(o_addr), int'(vt[i].dir));
      chk($sformatf("v%0d_doe", i), o_doe, vt[i].exp_doe);
      chk($sformatf("v%0d_data", i), int'(o_data), int'(vt[i].exp_data));
      chk($sformatf("v%0d_rdata", i), int'(o_rd), int'(vt[i].exp_rdata));
    end

    // Overlapping request held from cycle 3 to cycle 10.
    @(negedge clk);
    bus.wr_en = 1'b1; bus.dir = REG_MIN; bus.wdata = 8'h33;
    bus.act_rtc = 1'b1;
    @(posedge clk);
    #1 bus.act_rtc = 1'b0;
    dn = 0; o_addr = '0; o_data = '0; cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 3) begin
        bus.dir = 8'h99; bus.wdata = 8'h77; bus.act_rtc = 1'b1;
      end
      if (c == 11) bus.act_rtc = 1'b0;
      if (!bus.rtc_cs_n && !bus.rtc_ad) o_addr = bus.rtc_dq_o;
      if (!bus.rtc_cs_n && bus.rtc_ad && bus.rtc_dq_oe) o_data = bus.rtc_dq_o;
      if (bus.busy) cnt++;
      if (bus.done) dn++;
    end
    chk("ovl_done", dn, 1);
    chk("ovl_busy", cnt, 25);
    chk("ovl_addr", int'(o_addr), int'(REG_MIN));
    chk("ovl_data", int'(o_data), 'h33);

    // Reset during the data strobe of a write.
    @(negedge clk);
    bus.wr_en = 1'b1; bus.dir = REG_MON; bus.wdata = 8'h77;
    bus.act_rtc = 1'b1;
    @(posedge clk);
    #1 bus.act_rtc = 1'b0;
    repeat (19) @(negedge clk);
    chk("pre_rst_wr_n", int'({bus.rtc_cs_n, bus.rtc_wr_n, bus.rtc_ad}), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pins", int'({bus.rtc_cs_n, bus.rtc_wr_n,
        bus.rtc_dq_oe, bus.busy, bus.done}), 'h18);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b1, REG_TMR2, 8'hC3, 8'h00);
    chk("post_rst_lat", o_lat, 25);
    chk("post_rst_addr", int'(o_addr), int'(REG_TMR2));
    chk("post_rst_data", int'(o_data), 'hC3);

    // Back-to-back with act_rtc held high.
    @(negedge clk);
    bus.wr_en = 1'b0; bus.dir = REG_DAY; bus.rtc_dq_i = 8'h3C;
    bus.act_rtc = 1'b1;
    cnt = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.done) begin cnt = c; break; end
    end
    chk("b2b_first_lat", cnt, 25);
    @(negedge clk);
    chk("b2b_idle", int'({bus.busy, bus.rtc_cs_n}), 1);
    @(negedge clk);
    chk("b2b_restart", int'({bus.busy, bus.rtc_cs_n}), 2);
    bus.act_rtc = 1'b0;
    cnt = 0;
    for (int c = 2; c <= 60; c++) begin
      @(negedge clk);
      if (bus.done) begin cnt = c; break; end
    end
    chk("b2b_second_lat", cnt, 25);
    chk("b2b_rdata", int'(bus.rdata), 'h3C);
    dn = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.busy) dn++;
    end
    chk("b2b_quiet", dn, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
